// File: rtl/dense_layer_param_pkg.sv
// Shared types and helpers for the parametrised dense layer engine:
// FSM state encoding, index-width helper and the output saturation function.
package dense_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Wide enough for any accumulator plus bias this block is built with.
  localparam int SAT_W = 64;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      acc_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_mac_unit.sv
// Signed multiply-accumulate slice: one DATA_W x DATA_W product per enabled
// cycle into an AW-bit accumulator; clear has priority over enable.
module dense_mac_unit #(
  parameter int DATA_W = 16,
  parameter int AW     = 40
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [AW-1:0]     o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [AW-1:0]       r_acc;

  assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + AW'(w_prod);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dense_layer_param.sv
// Fully-connected layer engine: y[o] = act(bias[o] + sum_i x[i]*w[o][i]),
// one MAC per cycle, run-time loadable memories, saturating registered outputs.
module dense_layer_param
  import dense_pkg::*;
#(
  parameter int IN_DIM  = 128,
  parameter int OUT_DIM = 9,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int RELU    = 0
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic                                in_we,
  input  logic [idx_w(IN_DIM)-1:0]            in_addr,
  input  logic signed [DATA_W-1:0]            in_data,
  input  logic                                w_we,
  input  logic [idx_w(IN_DIM*OUT_DIM)-1:0]    w_addr,
  input  logic signed [DATA_W-1:0]            w_data,
  input  logic                                b_we,
  input  logic [idx_w(OUT_DIM)-1:0]           b_addr,
  input  logic signed [DATA_W-1:0]            b_data,
  input  logic [idx_w(OUT_DIM)-1:0]           read_addr,
  output logic signed [ACC_W-1:0]             read_data
);

  localparam int IAW = idx_w(IN_DIM);
  localparam int WN  = IN_DIM * OUT_DIM;
  localparam int WAW = idx_w(WN);
  localparam int BAW = idx_w(OUT_DIM);
  localparam int AW  = 2*DATA_W + $clog2(IN_DIM) + 1;

  state_t           r_state;
  logic [IAW-1:0]   r_i;
  logic [BAW-1:0]   r_o;

  logic signed [DATA_W-1:0] r_x [IN_DIM];
  logic signed [DATA_W-1:0] r_w [WN];
  logic signed [DATA_W-1:0] r_b [OUT_DIM];
  logic signed [ACC_W-1:0]  r_out [OUT_DIM];

  logic                     w_busy;
  logic                     w_start_ok;
  logic                     w_last_i;
  logic                     w_last_o;
  logic [WAW-1:0]           w_w_idx;
  logic signed [AW-1:0]     w_acc;
  logic signed [SAT_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_res;

  assign w_busy     = (r_state == S_MAC) || (r_state == S_WB);
  assign w_start_ok = start && !w_busy;
  assign w_last_i   = (r_i == IAW'(IN_DIM - 1));
  assign w_last_o   = (r_o == BAW'(OUT_DIM - 1));
  assign w_w_idx    = WAW'(r_o) * WAW'(IN_DIM) + WAW'(r_i);
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);

  dense_mac_unit #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mac (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_start_ok || (r_state == S_WB)),
    .i_en   (r_state == S_MAC),
    .i_a    (r_x[r_i]),
    .i_b    (r_w[w_w_idx]),
    .o_acc  (w_acc)
  );

  assign w_sum = SAT_W'(w_acc) + SAT_W'(r_b[r_o]);

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_res = ACC_W'(saturate(w_sum, ACC_W));
    if (RELU != 0 && w_res[ACC_W-1]) w_res = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_MAC;
            r_i     <= '0;
            r_o     <= '0;
          end
        end
        S_MAC: begin
          if (w_last_i) r_state <= S_WB;
          else          r_i     <= r_i + IAW'(1);
        end
        S_WB: begin
          r_i <= '0;
          if (w_last_o) begin
            r_state <= S_DONE;
          end else begin
            r_o     <= r_o + BAW'(1);
            r_state <= S_MAC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: operand memories carry no reset; their contents are defined only
  // by host writes, and leaving them unreset keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (!w_busy) begin
      if (in_we && 32'(in_addr) < IN_DIM)     r_x[in_addr] <= in_data;
      if (w_we  && 32'(w_addr)  < WN)         r_w[w_addr]  <= w_data;
      if (b_we  && 32'(b_addr)  < OUT_DIM)    r_b[b_addr]  <= b_data;
    end
  end

  // Results are cleared on reset so a host never reads a stale run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < OUT_DIM; k++) r_out[k] <= '0;
    end else if (r_state == S_WB) begin
      r_out[r_o] <= w_res;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          read_data <= '0;
    else if (32'(read_addr) < OUT_DIM)    read_data <= r_out[read_addr];
    else                                  read_data <= '0;
  end

endmodule
